rcu_clk_sw_seq: RTL and testbench
=================================

# rcu_clk_sw_seq

Clock-switch sequencer for the reset/clock unit's core PLL path. Runs on the buffered low-frequency oscillator clock and sits directly upstream of the core clock mux and PLL wrapper. It accepts frequency-change requests, gates the core clock, falls back to the reference clock, reprograms the PLL and waits for lock with a timeout. It then switches back glitch-free and reports status. It also detects loss of lock in PLL mode and forces a safe fallback to the reference clock.

## Interface
- `CFG_WIDTH`, 3: width of the PLL frequency config (`clk_cfg`).
- `TMO_WIDTH`, 16: width of the lock-timeout counter.
- `SETTLE_CYC`, 8: cycles spent in each gate/mux settle state; must be ≥1.
- `LOCK_STABLE`, 4: consecutive synced-lock cycles that qualify lock; must be ≥1.
- `clk_i` in 1: reference clock (buffered LF oscillator).
- `rst_i` in 1: reset, synchronous, active-high (one clock; polarity and synchronicity fixed).
- `req_valid_i` in 1: switch request valid.
- `req_ready_o` out 1: sequencer can accept a request.
- `req_pll_en_i` in 1: 1 = run core from PLL; 0 = bypass to reference.
- `req_cfg_i` in CFG_WIDTH: PLL config for the request.
- `tmo_val_i` in TMO_WIDTH: lock timeout in cycles, sampled at accept; 0 disables the timeout.
- `pll_lock_i` in 1: raw PLL lock, asynchronous.
- `pll_en_o` out 1: PLL enable.
- `clk_cfg_o` out CFG_WIDTH: PLL config.
- `sel_pll_o` out 1: core mux select; 1 = PLL.
- `clk_gate_en_o` out 1: core clock gate enable.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: one-cycle pulse when a sequence completes successfully.
- `err_o` out 1: one-cycle pulse on lock timeout or lock loss.
- `cur_pll_o` out 1: core currently running from a locked PLL.

## Operation
- `pll_lock_i` passes through a 2-flop synchronizer to give `lock_s`. All FSM decisions use `lock_s`.
- FSM states:
  - IDLE
  - GATE
  - SW_REF
  - RECFG
  - LOCK_WAIT
  - SW_PLL
  - UNGATE
  - DONE
  - FAULT
- Accept: `req_ready_o = (state==IDLE) && !lost`, where `lost = cur_pll_o && !lock_s`. On `req_valid_i && req_ready_o`:
  - latch `req_pll_en_i`, `req_cfg_i` and `tmo_val_i`;
  - go to GATE.
- GATE: `clk_gate_en_o=0`; hold SETTLE_CYC cycles, then go to SW_REF.
- SW_REF: `sel_pll_o=0` and `cur_pll_o=0`; hold SETTLE_CYC cycles. Then:
  - if latched pll_en=1, go to RECFG;
  - otherwise set `pll_en_o=0` and go to UNGATE.
- RECFG (1 cycle): `pll_en_o=0` for this cycle, `clk_cfg_o` ← latched cfg, then go to LOCK_WAIT.
- LOCK_WAIT:
  - `pll_en_o=1`.
  - Stable counter increments while `lock_s=1` and clears when `lock_s=0`.
  - At count == LOCK_STABLE, go to SW_PLL.
  - Timeout counter increments every cycle. If `tmo≠0` and the counter reaches `tmo`, go to FAULT; a timeout takes priority over the stable count in the same cycle.
- SW_PLL: `sel_pll_o=1`; hold SETTLE_CYC cycles, then go to UNGATE.
- UNGATE (1 cycle): `clk_gate_en_o=1`; `cur_pll_o` ← (`sel_pll_o`). Go to DONE.
- DONE (1 cycle): `done_o=1`, then go to IDLE.
- Lock loss: if `lost` is seen in IDLE, go to GATE with a forced bypass request and set an internal fault flag. When that sequence reaches DONE it pulses `err_o` instead of `done_o`. A new request arriving in the same cycle is not accepted.
- FAULT (1 cycle): `pll_en_o=0`, `err_o=1`. `sel_pll_o` is already 0. Go to UNGATE (clock restored on reference); no `done_o` pulse follows.
- `busy_o = (state != IDLE)`.
- Requests arriving while busy are not accepted, since ready is low. A request that duplicates the current state still runs the full sequence.

## Timing
- Reset values:
  - `req_ready_o=1`
  - `pll_en_o=0`
  - `clk_cfg_o=0`
  - `sel_pll_o=0`
  - `clk_gate_en_o=1`
  - `busy_o=0`
  - `done_o=0`
  - `err_o=0`
  - `cur_pll_o=0`
  - state IDLE; all counters 0
- Reset mid-sequence: return to the reset values on the next edge, regardless of state.
- All outputs are registered except `req_ready_o` and `busy_o`, which decode from state.
- Accept at edge N puts GATE in effect from N+1; `clk_gate_en_o` falls at N+1.
- Bypass sequence: accept at N; `done_o` at N+2·SETTLE_CYC+2 (UNGATE at N+2S+1).
- PLL sequence: lock path adds 1 (RECFG) + lock-qualify time + SETTLE_CYC. Synchronizer latency is 2 cycles.
- `clk_gate_en_o` is low whenever `sel_pll_o` changes; a mux change never occurs with the gate open.

## Structure
- Shared package `rcu_pkg`:
  - FSM state enum `rcu_sw_state_e`;
  - default constants `RCU_SW_SETTLE_CYC` and `RCU_SW_LOCK_STABLE`.
- Sub-module: reuse the existing `sync` 2-flop cell for `pll_lock_i`; no other hierarchy.

## Test plan
- Reset then bypass request (pll_en=0) with S=8 → `clk_gate_en_o` low for cycles 1–17, `done_o` at cycle 18, `sel_pll_o=0`, `cur_pll_o=0`.
- PLL request cfg=3'd5, tmo=100, lock rises 20 cycles after RECFG → `clk_cfg_o=5`, `sel_pll_o=1` after LOCK_STABLE+2 synced cycles, `done_o` pulse, `cur_pll_o=1`.
- PLL request, tmo=50, lock never rises → `err_o` pulse exactly 50 cycles into LOCK_WAIT, `pll_en_o=0`, `sel_pll_o=0`, gate reopened, no `done_o`.
- Lock glitches high 2 cycles then low, with LOCK_STABLE=4 → stable counter clears and the FSM stays in LOCK_WAIT until 4 consecutive synced highs.
- In PLL mode, drop lock → fallback sequence runs, `sel_pll_o=0`, `err_o` pulse, `cur_pll_o=0`; a simultaneous request sees `req_ready_o=0`.
- Assert `rst_i` during LOCK_WAIT → next cycle all outputs are at their reset values and `req_ready_o=1`.

Source files
------------

// File: rtl/rcu_pkg.sv
`default_nettype none
// ============================================================================
// Package : rcu_pkg
// Brief   : Shared types and default constants for the reset/clock unit.
// Rev     : 1.0 - initial release
// ============================================================================
package rcu_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_GATE      = 4'd1,
        S_SW_REF    = 4'd2,
        S_RECFG     = 4'd3,
        S_LOCK_WAIT = 4'd4,
        S_SW_PLL    = 4'd5,
        S_UNGATE    = 4'd6,
        S_DONE      = 4'd7,
        S_FAULT     = 4'd8
    } rcu_sw_state_e;

    localparam int RCU_SW_SETTLE_CYC  = 8;
    localparam int RCU_SW_LOCK_STABLE = 4;

endpackage
`default_nettype wire

// File: rtl/sync.sv
`default_nettype none
// ============================================================================
// Module : sync
// Brief  : Two-flop synchronizer for a single asynchronous level signal.
// Rev    : 1.0 - initial release
// ============================================================================
module sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/rcu_clk_sw_seq.sv
`default_nettype none
// ============================================================================
// Module : rcu_clk_sw_seq
// Brief  : Core clock switch sequencer: gate, fall back to reference, program
//          the PLL, qualify lock with timeout, switch back and ungate.
// Rev    : 1.0 - initial release
// ============================================================================
module rcu_clk_sw_seq
    import rcu_pkg::*;
#(
    parameter int CFG_WIDTH   = 3,
    parameter int TMO_WIDTH   = 16,
    parameter int SETTLE_CYC  = RCU_SW_SETTLE_CYC,
    parameter int LOCK_STABLE = RCU_SW_LOCK_STABLE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_pll_en_i,
    input  logic [CFG_WIDTH-1:0] req_cfg_i,
    input  logic [TMO_WIDTH-1:0] tmo_val_i,
    input  logic                 pll_lock_i,
    output logic                 pll_en_o,
    output logic [CFG_WIDTH-1:0] clk_cfg_o,
    output logic                 sel_pll_o,
    output logic                 clk_gate_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 cur_pll_o
);

    localparam int                c_SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int                c_STB_W    = $clog2(LOCK_STABLE + 1);
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);
    localparam logic [c_STB_W-1:0] c_STB_LIM  = c_STB_W'(LOCK_STABLE);

    rcu_sw_state_e          r_state,      w_state_nxt;
    logic [c_SET_W-1:0]     r_cnt,        w_cnt_nxt;
    logic [c_STB_W-1:0]     r_stab,       w_stab_nxt;
    logic [TMO_WIDTH-1:0]   r_tmo_cnt,    w_tmo_cnt_nxt;
    logic                   r_req_pll_en, w_req_pll_en_nxt;
    logic [CFG_WIDTH-1:0]   r_req_cfg,    w_req_cfg_nxt;
    logic [TMO_WIDTH-1:0]   r_req_tmo,    w_req_tmo_nxt;
    logic                   r_lost_seq,   w_lost_seq_nxt;
    logic                   r_tmo_seq,    w_tmo_seq_nxt;
    logic                   r_pll_en,     w_pll_en_nxt;
    logic [CFG_WIDTH-1:0]   r_clk_cfg,    w_clk_cfg_nxt;
    logic                   r_sel_pll,    w_sel_pll_nxt;
    logic                   r_gate_en,    w_gate_en_nxt;
    logic                   r_done,       w_done_nxt;
    logic                   r_err,        w_err_nxt;
    logic                   r_cur_pll,    w_cur_pll_nxt;

    logic w_lock_s;
    logic w_lost;

    sync u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (pll_lock_i),
        .o_q (w_lock_s)
    );

    assign w_lost      = r_cur_pll && !w_lock_s;
    assign req_ready_o = (r_state == S_IDLE) && !w_lost;
    assign busy_o      = (r_state != S_IDLE);

    assign pll_en_o      = r_pll_en;
    assign clk_cfg_o     = r_clk_cfg;
    assign sel_pll_o     = r_sel_pll;
    assign clk_gate_en_o = r_gate_en;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign cur_pll_o     = r_cur_pll;

    // Output registers are loaded on the transition, so each action is visible
    // in the first cycle of the state that owns it.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = '0;
        w_stab_nxt       = '0;
        w_tmo_cnt_nxt    = '0;
        w_req_pll_en_nxt = r_req_pll_en;
        w_req_cfg_nxt    = r_req_cfg;
        w_req_tmo_nxt    = r_req_tmo;
        w_lost_seq_nxt   = r_lost_seq;
        w_tmo_seq_nxt    = r_tmo_seq;
        w_pll_en_nxt     = r_pll_en;
        w_clk_cfg_nxt    = r_clk_cfg;
        w_sel_pll_nxt    = r_sel_pll;
        w_gate_en_nxt    = r_gate_en;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_cur_pll_nxt    = r_cur_pll;

        unique case (r_state)
            S_IDLE: begin
                if (w_lost) begin
                    // Lock loss wins over any pending request: forced bypass.
                    w_state_nxt      = S_GATE;
                    w_gate_en_nxt    = 1'b0;
                    w_req_pll_en_nxt = 1'b0;
                    w_lost_seq_nxt   = 1'b1;
                    w_tmo_seq_nxt    = 1'b0;
                end else if (req_valid_i) begin
                    w_state_nxt      = S_GATE;
                    w_gate_en_nxt    = 1'b0;
                    w_req_pll_en_nxt = req_pll_en_i;
                    w_req_cfg_nxt    = req_cfg_i;
                    w_req_tmo_nxt    = tmo_val_i;
                    w_lost_seq_nxt   = 1'b0;
                    w_tmo_seq_nxt    = 1'b0;
                end
            end
            S_GATE: begin
                if (r_cnt == c_SET_LAST) begin
                    w_state_nxt   = S_SW_REF;
                    w_sel_pll_nxt = 1'b0;
                    w_cur_pll_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SW_REF: begin
                if (r_cnt == c_SET_LAST) begin
                    w_pll_en_nxt = 1'b0;
                    if (r_req_pll_en) begin
                        w_state_nxt   = S_RECFG;
                        w_clk_cfg_nxt = r_req_cfg;
                    end else begin
                        w_state_nxt = S_UNGATE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RECFG: begin
                w_state_nxt  = S_LOCK_WAIT;
                w_pll_en_nxt = 1'b1;
            end
            S_LOCK_WAIT: begin
                w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                w_stab_nxt    = w_lock_s ? (r_stab + 1'b1) : '0;
                if ((r_req_tmo != '0) && (w_tmo_cnt_nxt == r_req_tmo)) begin
                    w_state_nxt   = S_FAULT;
                    w_pll_en_nxt  = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_tmo_seq_nxt = 1'b1;
                    w_stab_nxt    = '0;
                    w_tmo_cnt_nxt = '0;
                end else if (r_stab == c_STB_LIM) begin
                    w_state_nxt   = S_SW_PLL;
                    w_sel_pll_nxt = 1'b1;
                    w_stab_nxt    = '0;
                    w_tmo_cnt_nxt = '0;
                end
            end
            S_SW_PLL: begin
                if (r_cnt == c_SET_LAST) begin
                    w_state_nxt = S_UNGATE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_UNGATE: begin
                w_state_nxt   = S_DONE;
                w_gate_en_nxt = 1'b1;
                w_cur_pll_nxt = r_sel_pll;
                // A timeout already reported its error in FAULT.
                w_done_nxt    = !r_lost_seq && !r_tmo_seq;
                w_err_nxt     = r_lost_seq;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                w_state_nxt = S_UNGATE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_stab       <= '0;
            r_tmo_cnt    <= '0;
            r_req_pll_en <= 1'b0;
            r_req_cfg    <= '0;
            r_req_tmo    <= '0;
            r_lost_seq   <= 1'b0;
            r_tmo_seq    <= 1'b0;
            r_pll_en     <= 1'b0;
            r_clk_cfg    <= '0;
            r_sel_pll    <= 1'b0;
            r_gate_en    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cur_pll    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stab       <= w_stab_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_req_pll_en <= w_req_pll_en_nxt;
            r_req_cfg    <= w_req_cfg_nxt;
            r_req_tmo    <= w_req_tmo_nxt;
            r_lost_seq   <= w_lost_seq_nxt;
            r_tmo_seq    <= w_tmo_seq_nxt;
            r_pll_en     <= w_pll_en_nxt;
            r_clk_cfg    <= w_clk_cfg_nxt;
            r_sel_pll    <= w_sel_pll_nxt;
            r_gate_en    <= w_gate_en_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_cur_pll    <= w_cur_pll_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rcu_clk_sw_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_rcu_clk_sw_seq
// Brief  : Self-checking bench for the core clock switch sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rcu_clk_sw_seq;

    localparam int S  = 8;
    localparam int LS = 4;

    typedef struct packed {
        logic        done;
        logic        err;
        logic        sel;
        logic        cur;
        logic        pll_en;
        logic        gate;
        logic [2:0]  cfg;
        logic [31:0] cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_pll_en = 1'b0;
    logic [2:0]  req_cfg = '0;
    logic [15:0] tmo_val = '0;
    logic        pll_lock = 1'b0;
    logic        pll_en_o;
    logic [2:0]  clk_cfg_o;
    logic        sel_pll_o;
    logic        clk_gate_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cur_pll_o;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    ev_t         exp_q[$];
    ev_t         mon_obs;
    ev_t         mon_want;
    logic        prev_sel;

    rcu_clk_sw_seq #(
        .CFG_WIDTH   (3),
        .TMO_WIDTH   (16),
        .SETTLE_CYC  (S),
        .LOCK_STABLE (LS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_pll_en_i  (req_pll_en),
        .req_cfg_i     (req_cfg),
        .tmo_val_i     (tmo_val),
        .pll_lock_i    (pll_lock),
        .pll_en_o      (pll_en_o),
        .clk_cfg_o     (clk_cfg_o),
        .sel_pll_o     (sel_pll_o),
        .clk_gate_en_o (clk_gate_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .cur_pll_o     (cur_pll_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input logic d, input logic e, input logic s, input logic c,
                                  input logic p, input logic g, input logic [2:0] cfg,
                                  input logic [31:0] cy);
        ev_t r;
        r.done = d; r.err = e; r.sel = s; r.cur = c;
        r.pll_en = p; r.gate = g; r.cfg = cfg; r.cyc = cy;
        return r;
    endfunction

    // Completion/error pulses are matched against the expected-event queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o || err_o) begin
                mon_obs = mk_ev(done_o, err_o, sel_pll_o, cur_pll_o, pll_en_o,
                                clk_gate_en_o, clk_cfg_o, cyc);
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got event %h, want none", mon_obs);
                end else begin
                    mon_want = exp_q.pop_front();
                    if (mon_obs !== mon_want)
                        $display("FAIL sb_event: got %h want %h", mon_obs, mon_want);
                    else
                        n_pass++;
                end
            end
            if (sel_pll_o !== prev_sel) begin
                n_chk++;
                if (clk_gate_en_o !== 1'b0)
                    $display("FAIL mux_gated: gate=%b at sel change, want 0", clk_gate_en_o);
                else
                    n_pass++;
            end
        end
        prev_sel = sel_pll_o;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic pe, input logic [2:0] cfg, input logic [15:0] tmo);
        req_valid  = 1'b1;
        req_pll_en = pe;
        req_cfg    = cfg;
        tmo_val    = tmo;
    endtask

    task automatic test_reset;
        logic [10:0] want;
        want = {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        step();
        step();
        n_chk++;
        if ({req_ready_o, pll_en_o, clk_cfg_o, sel_pll_o, clk_gate_en_o, busy_o, done_o,
             err_o, cur_pll_o} !== want)
            $display("FAIL reset_vals: got %b want %b", {req_ready_o, pll_en_o, clk_cfg_o,
                     sel_pll_o, clk_gate_en_o, busy_o, done_o, err_o, cur_pll_o}, want);
        else
            n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_bypass;
        int unsigned a;
        drive_req(1'b0, 3'd2, 16'd0);
        n_chk++;
        if (req_ready_o !== 1'b1) $display("FAIL byp_ready: got %b want 1", req_ready_o);
        else n_pass++;
        step();
        a = cyc;
        req_valid = 1'b0;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, a + 17));
        for (int k = 0; k < 17; k++) begin
            n_chk++;
            if ({clk_gate_en_o, done_o, busy_o} !== 3'b001)
                $display("FAIL byp_gated k=%0d: got gate/done/busy %b want 001", k,
                         {clk_gate_en_o, done_o, busy_o});
            else n_pass++;
            step();
        end
        n_chk++;
        if ({done_o, clk_gate_en_o, sel_pll_o, cur_pll_o} !== 4'b1100)
            $display("FAIL byp_done: got done/gate/sel/cur %b want 1100",
                     {done_o, clk_gate_en_o, sel_pll_o, cur_pll_o});
        else n_pass++;
        step();
        n_chk++;
        if ({done_o, req_ready_o} !== 2'b01)
            $display("FAIL byp_after: got done/ready %b want 01", {done_o, req_ready_o});
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL byp_pending: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_pll;
        int unsigned a;
        drive_req(1'b1, 3'd5, 16'd100);
        step();
        a = cyc;
        req_valid = 1'b0;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, a + 52));
        for (int k = 0; k < 54; k++) begin
            if (k == 16) begin
                n_chk++;
                if ({pll_en_o, clk_cfg_o} !== {1'b0, 3'd5})
                    $display("FAIL pll_recfg: got en/cfg %b want 0101", {pll_en_o, clk_cfg_o});
                else n_pass++;
            end
            if (k == 17) begin
                n_chk++;
                if (pll_en_o !== 1'b1) $display("FAIL pll_en: got %b want 1", pll_en_o);
                else n_pass++;
            end
            if (k == 42) begin
                n_chk++;
                if (sel_pll_o !== 1'b0) $display("FAIL pll_sel_early: got %b want 0", sel_pll_o);
                else n_pass++;
            end
            if (k == 43) begin
                n_chk++;
                if ({sel_pll_o, clk_gate_en_o} !== 2'b10)
                    $display("FAIL pll_sel: got sel/gate %b want 10", {sel_pll_o, clk_gate_en_o});
                else n_pass++;
            end
            if (k == 52) begin
                n_chk++;
                if ({done_o, clk_gate_en_o, cur_pll_o, sel_pll_o} !== 4'b1111)
                    $display("FAIL pll_done: got done/gate/cur/sel %b want 1111",
                             {done_o, clk_gate_en_o, cur_pll_o, sel_pll_o});
                else n_pass++;
            end
            if (k == 36) pll_lock = 1'b1;
            step();
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL pll_pending: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_lock_loss;
        int unsigned a;
        pll_lock = 1'b0;
        step();
        n_chk++;
        if (req_ready_o !== 1'b1) $display("FAIL loss_ready_pre: got %b want 1", req_ready_o);
        else n_pass++;
        step();
        drive_req(1'b1, 3'd7, 16'd0);
        n_chk++;
        if ({req_ready_o, busy_o} !== 2'b00)
            $display("FAIL loss_ready: got ready/busy %b want 00", {req_ready_o, busy_o});
        else n_pass++;
        step();
        a = cyc;
        req_valid = 1'b0;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, a + 17));
        for (int k = 0; k < 19; k++) begin
            if (k == 7) begin
                n_chk++;
                if ({sel_pll_o, cur_pll_o, clk_gate_en_o} !== 3'b110)
                    $display("FAIL loss_gate: got sel/cur/gate %b want 110",
                             {sel_pll_o, cur_pll_o, clk_gate_en_o});
                else n_pass++;
            end
            if (k == 8) begin
                n_chk++;
                if ({sel_pll_o, cur_pll_o} !== 2'b00)
                    $display("FAIL loss_swref: got sel/cur %b want 00", {sel_pll_o, cur_pll_o});
                else n_pass++;
            end
            if (k == 17) begin
                n_chk++;
                if ({err_o, done_o, clk_gate_en_o, cur_pll_o} !== 4'b1010)
                    $display("FAIL loss_err: got err/done/gate/cur %b want 1010",
                             {err_o, done_o, clk_gate_en_o, cur_pll_o});
                else n_pass++;
            end
            if (k == 18) begin
                n_chk++;
                if ({busy_o, err_o} !== 2'b00)
                    $display("FAIL loss_idle: got busy/err %b want 00", {busy_o, err_o});
                else n_pass++;
            end
            step();
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL loss_pending: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_timeout;
        int unsigned a;
        drive_req(1'b1, 3'd6, 16'd50);
        step();
        a = cyc;
        req_valid = 1'b0;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, a + 67));
        for (int k = 0; k < 71; k++) begin
            if (k == 66) begin
                n_chk++;
                if ({err_o, pll_en_o} !== 2'b01)
                    $display("FAIL tmo_early: got err/en %b want 01", {err_o, pll_en_o});
                else n_pass++;
            end
            if (k == 67) begin
                n_chk++;
                if ({err_o, pll_en_o, sel_pll_o, clk_gate_en_o} !== 4'b1000)
                    $display("FAIL tmo_fault: got err/en/sel/gate %b want 1000",
                             {err_o, pll_en_o, sel_pll_o, clk_gate_en_o});
                else n_pass++;
            end
            if (k == 69) begin
                n_chk++;
                if ({clk_gate_en_o, done_o, err_o} !== 3'b100)
                    $display("FAIL tmo_ungate: got gate/done/err %b want 100",
                             {clk_gate_en_o, done_o, err_o});
                else n_pass++;
            end
            if (k == 70) begin
                n_chk++;
                if ({busy_o, done_o, err_o} !== 3'b000)
                    $display("FAIL tmo_idle: got busy/done/err %b want 000",
                             {busy_o, done_o, err_o});
                else n_pass++;
            end
            step();
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL tmo_pending: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_glitch;
        int unsigned a;
        drive_req(1'b1, 3'd1, 16'd0);
        step();
        a = cyc;
        req_valid = 1'b0;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, a + 46));
        for (int k = 0; k < 48; k++) begin
            if (k >= 17 && k <= 36) begin
                n_chk++;
                if ({sel_pll_o, pll_en_o} !== 2'b01)
                    $display("FAIL glitch_wait k=%0d: got sel/en %b want 01", k,
                             {sel_pll_o, pll_en_o});
                else n_pass++;
            end
            if (k == 37) begin
                n_chk++;
                if (sel_pll_o !== 1'b1) $display("FAIL glitch_sel: got %b want 1", sel_pll_o);
                else n_pass++;
            end
            if (k == 20) pll_lock = 1'b1;
            if (k == 22) pll_lock = 1'b0;
            if (k == 30) pll_lock = 1'b1;
            step();
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL glitch_pending: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [10:0] want;
        want = {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        drive_req(1'b1, 3'd2, 16'd0);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 18; k++) step();
        n_chk++;
        if ({pll_en_o, busy_o, sel_pll_o} !== 3'b110)
            $display("FAIL rstmid_pre: got en/busy/sel %b want 110", {pll_en_o, busy_o, sel_pll_o});
        else n_pass++;
        rst = 1'b1;
        step();
        n_chk++;
        if ({req_ready_o, pll_en_o, clk_cfg_o, sel_pll_o, clk_gate_en_o, busy_o, done_o,
             err_o, cur_pll_o} !== want)
            $display("FAIL rstmid_vals: got %b want %b", {req_ready_o, pll_en_o, clk_cfg_o,
                     sel_pll_o, clk_gate_en_o, busy_o, done_o, err_o, cur_pll_o}, want);
        else n_pass++;
        rst = 1'b0;
        step();
        step();
    endtask

    task automatic test_back_to_back;
        int unsigned a;
        drive_req(1'b0, 3'd3, 16'd0);
        step();
        a = cyc;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, a + 17));
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, a + 36));
        for (int k = 0; k < 38; k++) begin
            if (k <= 17) begin
                n_chk++;
                if (req_ready_o !== 1'b0)
                    $display("FAIL b2b_ready k=%0d: got %b want 0", k, req_ready_o);
                else n_pass++;
            end
            if (k == 18) begin
                n_chk++;
                if ({req_ready_o, busy_o} !== 2'b10)
                    $display("FAIL b2b_idle: got ready/busy %b want 10", {req_ready_o, busy_o});
                else n_pass++;
            end
            if (k == 19) begin
                req_valid = 1'b0;
                n_chk++;
                if ({busy_o, clk_gate_en_o} !== 2'b10)
                    $display("FAIL b2b_second: got busy/gate %b want 10", {busy_o, clk_gate_en_o});
                else n_pass++;
            end
            step();
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL b2b_pending: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        #1;
        test_reset();
        test_bypass();
        test_pll();
        test_lock_loss();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
